// File: rtl/audio_i2s_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_out_if
//  Description : Signal bundle for the audio output stage. Carries the
//                enable and the PSG/PCM stereo sample inputs toward the
//                output stage, and the PSG pacing strobe and the I2S pins
//                away from it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    enable      audio output enable (low holds the stage idle)
//    psg_left    PSG left sample, signed 16-bit
//    psg_right   PSG right sample, signed 16-bit
//    pcm_left    PCM left sample, signed 16-bit
//    pcm_right   PCM right sample, signed 16-bit
//    next_sample one-clk strobe to the PSG at each frame start
//    i2s_bclk    I2S bit clock (clk/8)
//    i2s_lrck    I2S word select (0 = left, 1 = right)
//    i2s_data    I2S serial data, MSB first
//  Modports
//    master  sample source side (drives enable and samples)
//    slave   the audio output stage
// ============================================================================
interface audio_i2s_out_if;
    logic        enable;
    logic [15:0] psg_left;
    logic [15:0] psg_right;
    logic [15:0] pcm_left;
    logic [15:0] pcm_right;
    logic        next_sample;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_data;

    modport master (
        output enable,
        output psg_left,
        output psg_right,
        output pcm_left,
        output pcm_right,
        input  next_sample,
        input  i2s_bclk,
        input  i2s_lrck,
        input  i2s_data
    );

    modport slave (
        input  enable,
        input  psg_left,
        input  psg_right,
        input  pcm_left,
        input  pcm_right,
        output next_sample,
        output i2s_bclk,
        output i2s_lrck,
        output i2s_data
    );
endinterface
`default_nettype wire

// File: rtl/audio_i2s_out.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_out
//  Description : Audio output stage behind the PSG. Paces the PSG with a
//                once-per-frame next_sample strobe, mixes PSG and PCM stereo
//                samples, and serializes the mix as 16-bit I2S. The frame is
//                512 clk long (8 clk per bit, 32 bit slots per channel).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   system clock, rising edge
//    rst   in   asynchronous active-high reset
//    bus   slave modport of audio_i2s_out_if (enable, samples, I2S pins,
//               next_sample)
//  Build option
//    AUDIO_OUT_SATURATE_EN  defined   : mix = clamp(psg + pcm) to 16 bits
//                           undefined : mix = (psg + pcm) >>> 1
// ============================================================================
module audio_i2s_out (
    input  wire logic            clk,
    input  wire logic            rst,
    audio_i2s_out_if.slave       bus
);

    localparam logic [8:0]  C_FC_LAST     = 9'd511;
    localparam logic [4:0]  C_SLOT_LAST   = 5'd16;
    localparam logic [15:0] C_POS_FULL    = 16'h7FFF;
    localparam logic [15:0] C_NEG_FULL    = 16'h8000;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [8:0]  r_fc;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic        r_next_sample;
    logic        r_bclk;
    logic        r_lrck;
    logic        r_data;

    // ------------------------------------------------------------------------
    // Mixer: 17-bit sums of sign-extended operands, then reduced to 16 bits
    // ------------------------------------------------------------------------
    logic [16:0] w_sum_left;
    logic [16:0] w_sum_right;
    logic [15:0] w_mix_left;
    logic [15:0] w_mix_right;

    assign w_sum_left  = {bus.psg_left[15],  bus.psg_left}
                       + {bus.pcm_left[15],  bus.pcm_left};
    assign w_sum_right = {bus.psg_right[15], bus.psg_right}
                       + {bus.pcm_right[15], bus.pcm_right};

`ifdef AUDIO_OUT_SATURATE_EN
    // A 17-bit sum fits in 16 bits exactly when its top two bits agree;
    // otherwise the sign bit tells which rail to clamp to.
    always_comb begin
        w_mix_left = w_sum_left[15:0];
        if (w_sum_left[16] != w_sum_left[15]) begin
            w_mix_left = w_sum_left[16] ? C_NEG_FULL : C_POS_FULL;
        end
    end

    always_comb begin
        w_mix_right = w_sum_right[15:0];
        if (w_sum_right[16] != w_sum_right[15]) begin
            w_mix_right = w_sum_right[16] ? C_NEG_FULL : C_POS_FULL;
        end
    end
`else
    // Arithmetic halving: the top 16 bits of the 17-bit sum never overflow.
    logic w_unused_lsbs;

    assign w_mix_left    = w_sum_left[16:1];
    assign w_mix_right   = w_sum_right[16:1];
    assign w_unused_lsbs = ^{w_sum_left[0], w_sum_right[0],
                             C_POS_FULL, C_NEG_FULL};
`endif

    // ------------------------------------------------------------------------
    // Serializer bit select
    //   slot s = fc[7:3]; slots 1..16 carry chan[16-s], everything else is 0.
    //   For s in 1..16, 16-s equals the 4-bit complement of (s-1), which
    //   also maps s=16 (low nibble 0) onto bit 0.
    // ------------------------------------------------------------------------
    logic [4:0]  w_slot;
    logic [3:0]  w_bit_idx;
    logic        w_in_word;
    logic [15:0] w_chan;
    logic        w_data_next;

    assign w_slot      = r_fc[7:3];
    assign w_bit_idx   = ~(w_slot[3:0] - 4'd1);
    assign w_in_word   = (w_slot != 5'd0) && (w_slot <= C_SLOT_LAST);
    assign w_chan      = r_fc[8] ? r_right : r_left;
    assign w_data_next = w_in_word ? w_chan[w_bit_idx] : 1'b0;

    // ------------------------------------------------------------------------
    // Frame counter, sample latches and output registers.
    // Every output is registered from the current fc, so all pins show
    // f(fc) one clk later and stay mutually aligned.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc          <= 9'd0;
            r_left        <= 16'd0;
            r_right       <= 16'd0;
            r_next_sample <= 1'b0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_data        <= 1'b0;
        end else if (!bus.enable) begin
            // Idle: abort any frame in progress, keep the latched samples.
            r_fc          <= 9'd0;
            r_next_sample <= 1'b0;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b0;
            r_data        <= 1'b0;
        end else begin
            r_fc          <= r_fc + 9'd1;
            r_next_sample <= (r_fc == 9'd0);
            r_bclk        <= r_fc[2];
            r_lrck        <= r_fc[8];
            r_data        <= w_data_next;
            // Inputs are only looked at here; the right-channel slot being
            // output at fc=511 is padding, so the new word is not yet in use.
            if (r_fc == C_FC_LAST) begin
                r_left  <= w_mix_left;
                r_right <= w_mix_right;
            end
        end
    end

    assign bus.next_sample = r_next_sample;
    assign bus.i2s_bclk    = r_bclk;
    assign bus.i2s_lrck    = r_lrck;
    assign bus.i2s_data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_out
//  Description : Directed self-checking bench for audio_i2s_out. Inputs are
//                driven and pins are sampled on the falling clk edge. The
//                bench tracks n, the frame position whose f(fc) the pins
//                currently show.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_out;

    logic clk = 1'b0;
    logic rst;

    audio_i2s_out_if bus ();

    audio_i2s_out dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

`ifdef AUDIO_OUT_SATURATE_EN
    localparam logic [15:0] EXP_SER_L   = 16'h8001;
    localparam logic [15:0] EXP_SER_R   = 16'h1234;
    localparam logic [15:0] EXP_CLIP_L  = 16'h7FFF;
    localparam logic [15:0] EXP_CLIP_R  = 16'h8000;
    localparam logic [15:0] EXP_SMALL_L = 16'h0003;
    localparam logic [15:0] EXP_SMALL_R = 16'hFFFE;
    localparam logic [15:0] EXP_A       = 16'h1000;
    localparam logic [15:0] EXP_C       = 16'h2000;
`else
    localparam logic [15:0] EXP_SER_L   = 16'hC000;
    localparam logic [15:0] EXP_SER_R   = 16'h091A;
    localparam logic [15:0] EXP_CLIP_L  = 16'h4800;
    localparam logic [15:0] EXP_CLIP_R  = 16'h9000;
    localparam logic [15:0] EXP_SMALL_L = 16'h0001;
    localparam logic [15:0] EXP_SMALL_R = 16'hFFFF;
    localparam logic [15:0] EXP_A       = 16'h0800;
    localparam logic [15:0] EXP_C       = 16'h1000;
`endif

    function automatic logic [3:0] outs();
        return {bus.next_sample, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_data};
    endfunction

    task automatic step();
        @(negedge clk);
        n = n + 1;
    endtask

    task automatic step_to(input int pos);
        do step(); while (n % 512 != pos);
    endtask

    task automatic set_inputs(input logic [15:0] pl, input logic [15:0] pr,
                              input logic [15:0] cl, input logic [15:0] cr);
        bus.psg_left  = pl;
        bus.psg_right = pr;
        bus.pcm_left  = cl;
        bus.pcm_right = cr;
    endtask

    // Runs one full frame from a frame end (or from a fresh enable) and
    // collects the data bit present at each rising edge of the bclk pin.
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r,
                                 output logic [31:0] pad, output int rises,
                                 output int pulses);
        logic [63:0] sh;
        logic        prev;
        sh     = '0;
        rises  = 0;
        pulses = 0;
        prev   = bus.i2s_bclk;
        for (int i = 0; i < 512; i++) begin
            step();
            if (bus.i2s_bclk === 1'b1 && prev === 1'b0) begin
                sh    = {sh[62:0], bus.i2s_data};
                rises = rises + 1;
            end
            if (bus.next_sample === 1'b1) pulses = pulses + 1;
            prev = bus.i2s_bclk;
        end
        l   = sh[62:47];
        r   = sh[30:15];
        pad = {sh[63], sh[46:32], sh[31], sh[14:0]};
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int bad;
        int pulses;
        rst        = 1'b1;
        bus.enable = 1'b0;
        set_inputs(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: outputs=%b required=0000", outs());
        end
        rst        = 1'b0;
        bus.enable = 1'b1;
        n          = 511;
        step_to(300);
        checks++;
        if (outs() !== 4'b0110) begin
            failures++;
            $display("FAIL pre_reset_pins: outputs=%b required=0110", outs());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: outputs=%b required=0000", outs());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold: outputs=%b required=0000", outs());
        end
        rst = 1'b0;
        n   = 511;
        step();
        checks++;
        if (outs() !== 4'b1000) begin
            failures++;
            $display("FAIL restart_fc0: outputs=%b required=1000", outs());
        end
        bus.enable = 1'b0;
        bad    = 0;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (outs() !== 4'b0000) bad++;
            if (bus.next_sample === 1'b1) pulses++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_outputs: nonzero_cycles=%0d required=0", bad);
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL idle_next_sample: pulses=%0d required=0", pulses);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_frame_timing();
        int bclk_bad, lrck_bad, ns_bad, data_bad, pulses, gap_bad, last_pulse;
        logic [8:0] m;
        bclk_bad = 0; lrck_bad = 0; ns_bad = 0; data_bad = 0;
        pulses = 0; gap_bad = 0; last_pulse = -1;
        set_inputs(16'h0, 16'h0, 16'h0, 16'h0);
        bus.enable = 1'b1;
        n = 511;
        for (int i = 0; i < 2560; i++) begin
            step();
            m = n[8:0];
            if (bus.i2s_bclk !== m[2]) bclk_bad++;
            if (bus.i2s_lrck !== m[8]) lrck_bad++;
            if (bus.next_sample !== (m == 9'd0)) ns_bad++;
            if (bus.i2s_data !== 1'b0) data_bad++;
            if (bus.next_sample === 1'b1) begin
                pulses++;
                if (last_pulse >= 0 && (n - last_pulse) != 512) gap_bad++;
                last_pulse = n;
            end
        end
        checks++;
        if (bclk_bad !== 0) begin
            failures++;
            $display("FAIL bclk_timing: bad_cycles=%0d required=0", bclk_bad);
        end
        checks++;
        if (lrck_bad !== 0) begin
            failures++;
            $display("FAIL lrck_timing: bad_cycles=%0d required=0", lrck_bad);
        end
        checks++;
        if (ns_bad !== 0) begin
            failures++;
            $display("FAIL next_sample_timing: bad_cycles=%0d required=0", ns_bad);
        end
        checks++;
        if (data_bad !== 0) begin
            failures++;
            $display("FAIL zero_data: bad_cycles=%0d required=0", data_bad);
        end
        checks++;
        if (pulses !== 5 || gap_bad !== 0) begin
            failures++;
            $display("FAIL next_sample_period: pulses=%0d bad_gaps=%0d required=5 and 0",
                     pulses, gap_bad);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_serialization();
        logic [15:0] l, r;
        logic [31:0] pad;
        int rises, pulses;
        set_inputs(16'h8001, 16'h1234, 16'h0000, 16'h0000);
        step_to(511);
        capture_frame(l, r, pad, rises, pulses);
        checks++;
        if (rises !== 64) begin
            failures++;
            $display("FAIL ser_bclk_rises: got=%0d required=64", rises);
        end
        checks++;
        if (l !== EXP_SER_L) begin
            failures++;
            $display("FAIL ser_left: got=%h required=%h", l, EXP_SER_L);
        end
        checks++;
        if (r !== EXP_SER_R) begin
            failures++;
            $display("FAIL ser_right: got=%h required=%h", r, EXP_SER_R);
        end
        checks++;
        if (pad !== 32'h0) begin
            failures++;
            $display("FAIL ser_padding: got=%h required=00000000", pad);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_mixing();
        logic [15:0] l, r;
        logic [31:0] pad;
        int rises, pulses;
        set_inputs(16'h7000, 16'h9000, 16'h2000, 16'h9000);
        step_to(511);
        capture_frame(l, r, pad, rises, pulses);
        checks++;
        if (l !== EXP_CLIP_L) begin
            failures++;
            $display("FAIL mix_pos_left: got=%h required=%h", l, EXP_CLIP_L);
        end
        checks++;
        if (r !== EXP_CLIP_R) begin
            failures++;
            $display("FAIL mix_neg_right: got=%h required=%h", r, EXP_CLIP_R);
        end
        set_inputs(16'h0003, 16'hFFFF, 16'h0000, 16'hFFFF);
        step_to(511);
        capture_frame(l, r, pad, rises, pulses);
        checks++;
        if (l !== EXP_SMALL_L) begin
            failures++;
            $display("FAIL mix_small_left: got=%h required=%h", l, EXP_SMALL_L);
        end
        checks++;
        if (r !== EXP_SMALL_R) begin
            failures++;
            $display("FAIL mix_small_right: got=%h required=%h", r, EXP_SMALL_R);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_input_timing();
        logic [15:0] l, r;
        logic [31:0] pad;
        int rises, pulses;
        set_inputs(16'h1000, 16'h0000, 16'h0000, 16'h0000);
        step_to(511);
        step_to(300);
        bus.psg_left = 16'h7F00;
        step_to(400);
        bus.psg_left = 16'h1000;
        step_to(511);
        capture_frame(l, r, pad, rises, pulses);
        checks++;
        if (l !== EXP_A || r !== 16'h0000) begin
            failures++;
            $display("FAIL glitch_not_captured: got=%h/%h required=%h/0000", l, r, EXP_A);
        end
        // Change one clk before the latch, then change again right after it.
        step_to(510);
        bus.psg_left = 16'h2000;
        step();
        bus.psg_left = 16'h7F00;
        capture_frame(l, r, pad, rises, pulses);
        checks++;
        if (l !== EXP_C) begin
            failures++;
            $display("FAIL late_change_left: got=%h required=%h", l, EXP_C);
        end
        checks++;
        if (pad !== 32'h0 || rises !== 64) begin
            failures++;
            $display("FAIL late_change_frame: pad=%h rises=%0d required=00000000 and 64",
                     pad, rises);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_enable_drop();
        logic [15:0] l, r;
        logic [31:0] pad;
        int rises, pulses, bad;
        bus.psg_left = 16'h2000;
        step_to(511);
        step_to(100);
        checks++;
        if (outs() !== 4'b0100) begin
            failures++;
            $display("FAIL pre_drop_pins: outputs=%b required=0100", outs());
        end
        bus.enable = 1'b0;
        step();
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL drop_outputs: outputs=%b required=0000", outs());
        end
        bus.psg_left = 16'h7F00;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (outs() !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL drop_hold: nonzero_cycles=%0d required=0", bad);
        end
        bus.enable = 1'b1;
        n = 511;
        capture_frame(l, r, pad, rises, pulses);
        checks++;
        if (pulses !== 1 || rises !== 64) begin
            failures++;
            $display("FAIL reenable_frame: pulses=%0d rises=%0d required=1 and 64",
                     pulses, rises);
        end
        checks++;
        if (l !== EXP_C || r !== 16'h0000 || pad !== 32'h0) begin
            failures++;
            $display("FAIL reenable_kept_sample: got=%h/%h pad=%h required=%h/0000 pad=0",
                     l, r, pad, EXP_C);
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_serialization();
        test_mixing();
        test_input_timing();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
